// File: rtl/lab2_pkg.sv
// Shared types and default parameters for the lab2 response checker.
package lab2_pkg;

    // Checker run phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Default input width of the circuit under test.
    localparam int N_IN_DEF = 3;

    // Default golden table: 3-input majority, bit k is the output for input k.
    localparam logic [7:0] TRUTH_DEF = 8'b1110_1000;

    // Default number of consecutive idle cycles before a run is abandoned.
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/lab2_ref_model.sv
// Golden reference for the lab2 circuit: a plain truth-table lookup.
// Replaceable by a gate-level model with the same ports.
module lab2_ref_model
    import lab2_pkg::*;
#(
    parameter int                   N_IN  = N_IN_DEF,
    parameter logic [(1<<N_IN)-1:0] TRUTH = TRUTH_DEF
) (
    input  logic [N_IN-1:0] vec_in,
    output logic            expected
);

    // Expected output is the table bit selected by the applied vector.
    always_comb begin
        expected = TRUTH[vec_in];
    end

endmodule

// File: rtl/lab2_checker.sv
// Response checker for the lab2 circuit: compares each returned output
// against the golden model, tracks input coverage, and produces a single
// registered pass/fail verdict when coverage completes or the run stalls.
module lab2_checker
    import lab2_pkg::*;
#(
    parameter int                   N_IN    = N_IN_DEF,
    parameter logic [(1<<N_IN)-1:0] TRUTH   = TRUTH_DEF,
    parameter int                   TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 vec_valid,
    input  logic [N_IN-1:0]      vec_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [N_IN:0]        err_count,
    output logic [(1<<N_IN)-1:0] cov_map,
    output logic                 first_fail_valid,
    output logic [N_IN-1:0]      first_fail_vec
);

    localparam int DEPTH = 1 << N_IN;
    localparam int CW    = N_IN + 1;
    localparam int IW    = $clog2(TIMEOUT + 1);

    // Mismatch counter increment that sticks at all-ones.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state_q, state_d;
    logic               busy_d, done_d, pass_d, timeout_d;
    logic [CW-1:0]      err_d;
    logic [DEPTH-1:0]   cov_d;
    logic               ffv_d;
    logic [N_IN-1:0]    ffvec_d;
    logic [IW-1:0]      idle_q, idle_d;

    logic               expected;
    logic               mismatch;
    logic [DEPTH-1:0]   cov_hit;
    logic [IW-1:0]      idle_inc;

    lab2_ref_model #(
        .N_IN  (N_IN),
        .TRUTH (TRUTH)
    ) u_ref (
        .vec_in   (vec_in),
        .expected (expected)
    );

    // Next-state, counters, coverage and verdict for the current cycle.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy;
        done_d    = done;
        pass_d    = pass;
        timeout_d = timeout;
        err_d     = err_count;
        cov_d     = cov_map;
        ffv_d     = first_fail_valid;
        ffvec_d   = first_fail_vec;
        idle_d    = idle_q;

        mismatch  = (dut_out != expected);
        // Coverage including the sample being presented now, so the
        // completing sample ends the run on the same edge.
        cov_hit   = cov_map | (DEPTH'(1) << vec_in);
        idle_inc  = idle_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new run wipes every result; any concurrent sample is dropped.
                if (start) begin
                    state_d   = ST_CHECK;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_d     = '0;
                    cov_d     = '0;
                    ffv_d     = 1'b0;
                    ffvec_d   = '0;
                    idle_d    = '0;
                end
            end
            ST_CHECK: begin
                if (vec_valid) begin
                    idle_d = '0;
                    cov_d  = cov_hit;
                    if (mismatch) begin
                        err_d = sat_inc(err_count);
                        if (!first_fail_valid) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_in;
                        end
                    end
                    if (&cov_hit) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count == '0) && !mismatch && !timeout;
                    end
                end else begin
                    idle_d = idle_inc;
                    if (idle_inc == IW'(TIMEOUT)) begin
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset discards any partial run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            timeout          <= 1'b0;
            err_count        <= '0;
            cov_map          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            idle_q           <= '0;
        end else begin
            state_q          <= state_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            timeout          <= timeout_d;
            err_count        <= err_d;
            cov_map          <= cov_d;
            first_fail_valid <= ffv_d;
            first_fail_vec   <= ffvec_d;
            idle_q           <= idle_d;
        end
    end

endmodule

// File: tb/tb_lab2_checker.sv
// Testbench for lab2_checker: directed scenarios plus randomized runs
// against a behavioural model of the checker's rules.
module tb_lab2_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic [2:0] vec_in = '0;
    logic       dut_out = 1'b0;
    logic       busy, done, pass, timeout;
    logic [3:0] err_count;
    logic [7:0] cov_map;
    logic       first_fail_valid;
    logic [2:0] first_fail_vec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lab2_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .vec_valid        (vec_valid),
        .vec_in           (vec_in),
        .dut_out          (dut_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout),
        .err_count        (err_count),
        .cov_map          (cov_map),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec)
    );

    // ---------------- behavioural model ----------------
    // Phase: 0 idle, 1 checking, 2 finished.
    int  m_phase = 0;
    int  m_err   = 0;
    bit  m_seen [8];
    bit  m_ffv   = 0;
    int  m_ffvec = 0;
    int  m_idle  = 0;
    bit  m_to    = 0;
    bit  m_pass  = 0;

    // The lab2 circuit is a 3-input majority gate.
    function automatic logic golden(input logic [2:0] v);
        return ($countones(v) >= 2);
    endfunction

    function automatic int seen_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_seen[i];
        return c;
    endfunction

    function automatic logic [7:0] seen_vec();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = m_seen[i];
        return r;
    endfunction

    function automatic void model_clear();
        m_err = 0; m_ffv = 0; m_ffvec = 0; m_idle = 0; m_to = 0; m_pass = 0;
        for (int i = 0; i < 8; i++) m_seen[i] = 0;
    endfunction

    function automatic void model_update(input logic r, input logic s, input logic v,
                                         input logic [2:0] vc, input logic o);
        if (!r) begin
            model_clear();
            m_phase = 0;
        end else if (m_phase != 1) begin
            if (s) begin
                model_clear();
                m_phase = 1;
            end
        end else if (v) begin
            m_idle = 0;
            if (o != golden(vc)) begin
                if (m_err < 15) m_err++;
                if (!m_ffv) begin m_ffv = 1; m_ffvec = vc; end
            end
            m_seen[vc] = 1;
            if (seen_count() == 8) begin
                m_phase = 2;
                m_pass  = (m_err == 0) && !m_to;
            end
        end else begin
            m_idle++;
            if (m_idle == 64) begin
                m_to = 1; m_pass = 0; m_phase = 2;
            end
        end
    endfunction

    // Apply one cycle of inputs, let the edge happen, advance the model.
    task automatic drive(input logic r, input logic s, input logic v,
                         input logic [2:0] vc, input logic o);
        rst_n = r; start = s; vec_valid = v; vec_in = vc; dut_out = o;
        @(posedge clk); #1;
        model_update(r, s, v, vc, o);
        rst_n = 1'b1; start = 1'b0; vec_valid = 1'b0;
    endtask

    // Full 0..7 sweep; bad_vec (if 0..7) gets an inverted output.
    task automatic sweep(input int bad_vec);
        for (int k = 0; k < 8; k++)
            drive(1, 0, 1, 3'(k), golden(3'(k)) ^ (k == bad_vec));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(0, 0, 0, 3'd0, 0);
        drive(0, 0, 0, 3'd0, 0);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_tests++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b want 0", pass); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
        n_tests++; if (err_count !== 4'h0) begin n_fail++; $display("FAIL reset_err: got %h want 0", err_count); end
        n_tests++; if (cov_map !== 8'h00) begin n_fail++; $display("FAIL reset_cov: got %h want 00", cov_map); end
        n_tests++; if ({first_fail_valid, first_fail_vec} !== 4'h0) begin n_fail++; $display("FAIL reset_ff: got %b%b want 0000", first_fail_valid, first_fail_vec); end
        // Samples in IDLE are ignored.
        drive(1, 0, 1, 3'd3, 0);
        n_tests++; if (cov_map !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore: cov %h busy %0b want 00/0", cov_map, busy); end
    endtask

    task automatic test_exhaustive_pass();
        drive(1, 1, 0, 3'd0, 0);
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL pass_start: busy %0b done %0b want 1/0", busy, done); end
        for (int k = 0; k < 7; k++) drive(1, 0, 1, 3'(k), golden(3'(k)));
        n_tests++; if (done !== 1'b0 || cov_map !== 8'h7F) begin n_fail++; $display("FAIL pass_pre: done %0b cov %h want 0/7f", done, cov_map); end
        drive(1, 0, 1, 3'd7, golden(3'd7));
        n_tests++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL pass_verdict: done %0b pass %0b busy %0b want 1/1/0", done, pass, busy); end
        n_tests++; if (err_count !== 4'h0 || cov_map !== 8'hFF) begin n_fail++; $display("FAIL pass_counts: err %h cov %h want 0/ff", err_count, cov_map); end
        // Samples in DONE are ignored.
        drive(1, 0, 1, 3'd0, 1);
        n_tests++; if (err_count !== 4'h0 || pass !== 1'b1) begin n_fail++; $display("FAIL done_ignore: err %h pass %0b want 0/1", err_count, pass); end
    endtask

    task automatic test_restart();
        drive(1, 1, 0, 3'd0, 0);
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL restart_state: busy %0b done %0b want 1/0", busy, done); end
        n_tests++; if (cov_map !== 8'h00 || err_count !== 4'h0 || pass !== 1'b0) begin n_fail++; $display("FAIL restart_clear: cov %h err %h pass %0b want 00/0/0", cov_map, err_count, pass); end
        // start is ignored while checking; the accompanying sample counts.
        drive(1, 1, 1, 3'd2, golden(3'd2));
        n_tests++; if (cov_map !== 8'h04 || busy !== 1'b1) begin n_fail++; $display("FAIL start_in_check: cov %h busy %0b want 04/1", cov_map, busy); end
        sweep(-1);
    endtask

    task automatic test_single_fault();
        drive(1, 1, 0, 3'd0, 0);
        sweep(5);
        n_tests++; if (err_count !== 4'h1) begin n_fail++; $display("FAIL fault_err: got %h want 1", err_count); end
        n_tests++; if (first_fail_valid !== 1'b1 || first_fail_vec !== 3'd5) begin n_fail++; $display("FAIL fault_first: valid %0b vec %0d want 1/5", first_fail_valid, first_fail_vec); end
        n_tests++; if (pass !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL fault_verdict: pass %0b done %0b want 0/1", pass, done); end
    endtask

    task automatic test_start_drops_sample();
        // From DONE, start together with a sample: the sample is dropped.
        drive(1, 1, 1, 3'd6, 0);
        n_tests++; if (cov_map !== 8'h00 || err_count !== 4'h0) begin n_fail++; $display("FAIL start_drop: cov %h err %h want 00/0", cov_map, err_count); end
    endtask

    task automatic test_dup_gaps();
        int seq [8] = '{0, 0, 1, 2, 3, 4, 5, 6};
        foreach (seq[i]) drive(1, 0, 1, 3'(seq[i]), golden(3'(seq[i])));
        n_tests++; if (cov_map !== 8'h7F || busy !== 1'b1) begin n_fail++; $display("FAIL dup_cov: cov %h busy %0b want 7f/1", cov_map, busy); end
        for (int i = 0; i < 63; i++) drive(1, 0, 0, 3'd0, 0);
        n_tests++; if (done !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL gap_early: done %0b timeout %0b want 0/0", done, timeout); end
        drive(1, 0, 0, 3'd0, 0);
        n_tests++; if (timeout !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL gap_timeout: timeout %0b done %0b pass %0b want 1/1/0", timeout, done, pass); end
    endtask

    task automatic test_saturation();
        drive(1, 1, 0, 3'd0, 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 1, 3'd0, ~golden(3'd0));
        n_tests++; if (err_count !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %h want f", err_count); end
        for (int k = 1; k < 8; k++) drive(1, 0, 1, 3'(k), golden(3'(k)));
        n_tests++; if (err_count !== 4'hF || first_fail_vec !== 3'd0 || first_fail_valid !== 1'b1) begin n_fail++; $display("FAIL sat_final: err %h ffvec %0d ffv %0b want f/0/1", err_count, first_fail_vec, first_fail_valid); end
        n_tests++; if (done !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL sat_verdict: done %0b pass %0b want 1/0", done, pass); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 3'd0, 0);
        for (int k = 0; k < 4; k++) drive(1, 0, 1, 3'(k), ~golden(3'(k)));
        drive(0, 0, 0, 3'd0, 0);
        n_tests++; if ({busy, done, pass, timeout} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 0000", {busy, done, pass, timeout}); end
        n_tests++; if (err_count !== 4'h0 || cov_map !== 8'h00 || first_fail_valid !== 1'b0 || first_fail_vec !== 3'd0) begin n_fail++; $display("FAIL rstmid_data: err %h cov %h ffv %0b ffvec %0d want 0/00/0/0", err_count, cov_map, first_fail_valid, first_fail_vec); end
        // Still in IDLE: a sample without start does nothing.
        drive(1, 0, 1, 3'd1, 0);
        n_tests++; if (busy !== 1'b0 || cov_map !== 8'h00) begin n_fail++; $display("FAIL rstmid_idle: busy %0b cov %h want 0/00", busy, cov_map); end
        drive(1, 1, 0, 3'd0, 0);
        sweep(-1);
        n_tests++; if (pass !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL rstmid_rerun: pass %0b done %0b want 1/1", pass, done); end
    endtask

    task automatic test_random();
        for (int run = 0; run < 6; run++) begin
            int cyc = 0;
            drive(1, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            while (m_phase == 1 && cyc < 400) begin
                logic       v  = ($urandom_range(0, 9) < 7);
                logic [2:0] vc = 3'($urandom_range(0, 7));
                logic       o  = golden(vc) ^ ($urandom_range(0, 9) == 0);
                logic       s  = ($urandom_range(0, 19) == 0);
                drive(1, s, v, vc, o);
                cyc++;
                n_tests++;
                if (busy !== (m_phase == 1) || done !== (m_phase == 2) || pass !== m_pass ||
                    timeout !== m_to || err_count !== 4'(m_err) || cov_map !== seen_vec() ||
                    first_fail_valid !== m_ffv || (m_ffv && first_fail_vec !== 3'(m_ffvec))) begin
                    n_fail++;
                    $display("FAIL random_r%0d_c%0d: got b%0b d%0b p%0b t%0b e%h c%h fv%0b f%0d want b%0b d%0b p%0b t%0b e%h c%h fv%0b f%0d",
                             run, cyc, busy, done, pass, timeout, err_count, cov_map, first_fail_valid, first_fail_vec,
                             m_phase == 1, m_phase == 2, m_pass, m_to, 4'(m_err), seen_vec(), m_ffv, m_ffvec);
                end
            end
            n_tests++;
            if (m_phase != 2) begin
                n_fail++;
                $display("FAIL random_r%0d_end: run did not finish within %0d cycles", run, cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive_pass();
        test_restart();
        test_single_fault();
        test_start_drops_sample();
        test_dup_gaps();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
